// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: state codes, funct3
// encodings, the latched-op and bus-request records, and the size-to-strobe helper.
package lsu_pkg;

  localparam int XLEN      = 64;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_RSP  = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_LWU  = 3'b110;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SD   = 3'b011;
  localparam logic [2:0] F3_RSVD = 3'b111;

  // Only the byte offset of the address is kept; the word address lives in the bus request.
  typedef struct packed {
    logic       ld;
    logic       st;
    logic [2:0] funct3;
    logic [2:0] off;
  } lsu_op_t;

  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [NUM_LANES-1:0] wstrb;
  } bus_req_t;

  function automatic logic [NUM_LANES-1:0] size_strb(input logic [1:0] sz);
    case (sz)
      2'b00:   size_strb = 8'h01;
      2'b01:   size_strb = 8'h03;
      2'b10:   size_strb = 8'h0F;
      default: size_strb = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment datapath: misalign detection, store lane placement
// and strobes, and load byte extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t              op,
  input  logic [XLEN-1:0]      st_data,
  input  logic [XLEN-1:0]      rsp_data,
  output logic                 misalign,
  output logic [XLEN-1:0]      wdata,
  output logic [NUM_LANES-1:0] wstrb,
  output logic [XLEN-1:0]      rdata
);

  logic [XLEN-1:0] shifted;
  logic            sext;

  always_comb begin
    misalign = 1'b0;
    if (op.ld || op.st) begin
      // Stores have no unsigned variants, so funct3[2] on a store is reserved.
      if (op.funct3 == F3_RSVD || (op.st && op.funct3[2])) begin
        misalign = 1'b1;
      end else begin
        case (op.funct3[1:0])
          2'b01:   misalign = op.off[0];
          2'b10:   misalign = |op.off[1:0];
          2'b11:   misalign = |op.off[2:0];
          default: misalign = 1'b0;
        endcase
      end
    end
  end

  assign wdata   = st_data << {op.off, 3'b000};
  assign wstrb   = size_strb(op.funct3[1:0]) << op.off;
  assign shifted = rsp_data >> {op.off, 3'b000};
  assign sext    = ~op.funct3[2];

  always_comb begin
    rdata = '0;
    case (op.funct3[1:0])
      2'b00:   rdata = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      2'b10:   rdata = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one EX result, runs at most one aligned bus access,
// and hands an extended load result to write-back via valid/ready.
module lsu
  import lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mem_r,
  input  logic                 mem_w,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      st_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ld_data,
  output logic                 misalign,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic                 bus_req_we,
  output logic [XLEN-1:0]      bus_req_addr,
  output logic [XLEN-1:0]      bus_req_wdata,
  output logic [NUM_LANES-1:0] bus_req_wstrb,
  input  logic                 bus_rsp_valid,
  input  logic [XLEN-1:0]      bus_rsp_data
);

  logic [1:0]           state;
  lsu_op_t              op_in, op_q, op_sel;
  bus_req_t             req_q;
  logic [XLEN-1:0]      ld_q;
  logic                 mis_q;
  logic                 al_mis;
  logic [XLEN-1:0]      al_wdata, al_rdata;
  logic [NUM_LANES-1:0] al_wstrb;
  logic                 accept;

  always_comb begin
    op_in.ld     = mem_r & ~mem_w;
    op_in.st     = mem_w;
    op_in.funct3 = funct3;
    op_in.off    = addr[2:0];
  end

  // In IDLE the aligner looks at the incoming op to decide the next state;
  // afterwards it sees the latched op so load extraction uses the accepted offset.
  assign op_sel = (state == LSU_IDLE) ? op_in : op_q;

  lsu_align u_align (
    .op       (op_sel),
    .st_data  (st_data),
    .rsp_data (bus_rsp_data),
    .misalign (al_mis),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .rdata    (al_rdata)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
      op_q  <= '0;
      req_q <= '0;
      ld_q  <= '0;
      mis_q <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: if (accept) begin
          op_q        <= op_in;
          mis_q       <= al_mis;
          ld_q        <= '0;
          req_q.we    <= op_in.st;
          req_q.addr  <= {addr[XLEN-1:3], 3'b000};
          req_q.wdata <= op_in.st ? al_wdata : '0;
          req_q.wstrb <= op_in.st ? al_wstrb : '0;
          state       <= ((op_in.ld || op_in.st) && !al_mis) ? LSU_REQ : LSU_DONE;
        end
        LSU_REQ: if (bus_req_ready) state <= LSU_RSP;
        LSU_RSP: if (bus_rsp_valid) begin
          if (op_q.ld) ld_q <= al_rdata;
          state <= LSU_DONE;
        end
        default: if (out_ready) state <= LSU_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once.
  assign in_ready      = (state == LSU_IDLE);
  assign bus_req_valid = (state == LSU_REQ);
  assign out_valid     = (state == LSU_DONE);
  assign bus_req_we    = req_q.we;
  assign bus_req_addr  = req_q.addr;
  assign bus_req_wdata = req_q.wdata;
  assign bus_req_wstrb = req_q.wstrb;
  assign ld_data       = ld_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed vectors for reset, loads, stores,
// misalignment, non-memory pass-through and backpressure.
module tb_lsu;
  import lsu_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, mem_r, mem_w;
  logic [2:0]      funct3;
  logic [63:0]     addr, st_data, ld_data;
  logic            out_valid, out_ready, misalign;
  logic            bus_req_valid, bus_req_ready, bus_req_we;
  logic [63:0]     bus_req_addr, bus_req_wdata;
  logic [7:0]      bus_req_wstrb;
  logic            bus_rsp_valid;
  logic [63:0]     bus_rsp_data;
  int              n_cmp = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_r(mem_r), .mem_w(mem_w), .funct3(funct3), .addr(addr), .st_data(st_data),
    .out_valid(out_valid), .out_ready(out_ready), .ld_data(ld_data), .misalign(misalign),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one op for the accept edge, then scrambles the inputs so held payload is visible.
  task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d);
    in_valid = 1'b1; mem_r = r; mem_w = w; funct3 = f3; addr = a; st_data = d;
    chk("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
    tick;
    in_valid = 1'b0; mem_r = 1'b0; mem_w = 1'b0; funct3 = 3'b111;
    addr = 64'hDEAD_BEEF_DEAD_BEEF; st_data = 64'hCAFE_CAFE_CAFE_CAFE;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mem_r = 1'b0; mem_w = 1'b0; funct3 = '0;
    addr = 64'h1234_5678_9ABC_DEF0; st_data = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    tick;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    chk("rst_ld_data", ld_data, 64'd0);
    chk("rst_req_addr", bus_req_addr, 64'd0);
    chk("rst_req_wdata", bus_req_wdata, 64'd0);
    chk("rst_req_wstrb", {56'd0, bus_req_wstrb}, 64'd0);
    rst_n = 1'b1;
    tick;

    // Reset while a request is stalled in REQ, then a late response in IDLE.
    issue(1'b1, 1'b0, F3_LB, 64'h0000_0000_4000_0010, 64'd0);
    chk("midreq_req_valid", {63'd0, bus_req_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreq_rst_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("midreq_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midreq_rst_out_valid", {63'd0, out_valid}, 64'd0);
    tick;
    rst_n = 1'b1; bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    bus_rsp_valid = 1'b0;
    chk("late_rsp_out_valid", {63'd0, out_valid}, 64'd0);
    chk("late_rsp_in_ready", {63'd0, in_ready}, 64'd1);
    chk("late_rsp_req_valid", {63'd0, bus_req_valid}, 64'd0);

    // LB at offset 3, sign-extended.
    issue(1'b1, 1'b0, F3_LB, 64'h0000_0000_8000_0003, 64'd0);
    chk("lb_req_valid", {63'd0, bus_req_valid}, 64'd1);
    chk("lb_req_addr", bus_req_addr, 64'h0000_0000_8000_0000);
    chk("lb_req_we", {63'd0, bus_req_we}, 64'd0);
    chk("lb_in_ready", {63'd0, in_ready}, 64'd0);
    tick;
    chk("lb_rsp_out_valid", {63'd0, out_valid}, 64'd0);
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'h0000_0000_8000_0000;
    tick;
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    chk("lb_out_valid", {63'd0, out_valid}, 64'd1);
    chk("lb_ld_data", ld_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_misalign", {63'd0, misalign}, 64'd0);
    chk("lb_done_in_ready", {63'd0, in_ready}, 64'd0);
    tick;
    chk("lb_back_idle", {63'd0, in_ready}, 64'd1);
    chk("lb_out_dropped", {63'd0, out_valid}, 64'd0);

    // LHU / LH at offset 6.
    issue(1'b1, 1'b0, F3_LHU, 64'h0000_0000_0000_1006, 64'd0);
    tick;
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'hBEEF_0000_0000_0000;
    tick;
    bus_rsp_valid = 1'b0;
    chk("lhu_ld_data", ld_data, 64'h0000_0000_0000_BEEF);
    tick;
    issue(1'b1, 1'b0, F3_LH, 64'h0000_0000_0000_1006, 64'd0);
    tick;
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'hBEEF_0000_0000_0000;
    tick;
    bus_rsp_valid = 1'b0;
    chk("lh_ld_data", ld_data, 64'hFFFF_FFFF_FFFF_BEEF);
    tick;

    // SW at offset 4 with a slow write ack.
    issue(1'b0, 1'b1, F3_SW, 64'h0000_0000_0000_1004, 64'h0000_0000_1122_3344);
    chk("sw_req_we", {63'd0, bus_req_we}, 64'd1);
    chk("sw_req_addr", bus_req_addr, 64'h0000_0000_0000_1000);
    chk("sw_wstrb", {56'd0, bus_req_wstrb}, 64'h0000_0000_0000_00F0);
    chk("sw_wdata", bus_req_wdata, 64'h1122_3344_0000_0000);
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("sw_wait_out_valid", {63'd0, out_valid}, 64'd0);
      tick;
    end
    chk("sw_still_waiting", {63'd0, out_valid}, 64'd0);
    bus_rsp_valid = 1'b1;
    tick;
    bus_rsp_valid = 1'b0;
    chk("sw_out_valid", {63'd0, out_valid}, 64'd1);
    chk("sw_ld_data", ld_data, 64'd0);
    chk("sw_misalign", {63'd0, misalign}, 64'd0);
    tick;

    // Misaligned LD: no bus access, result on the next cycle.
    issue(1'b1, 1'b0, F3_LD, 64'h0000_0000_0000_1004, 64'd0);
    chk("ld_mis_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("ld_mis_out_valid", {63'd0, out_valid}, 64'd1);
    chk("ld_mis_misalign", {63'd0, misalign}, 64'd1);
    chk("ld_mis_ld_data", ld_data, 64'd0);
    tick;

    // Store with funct3[2] set is reserved.
    issue(1'b0, 1'b1, 3'b100, 64'h0000_0000_0000_2000, 64'd5);
    chk("sbu_mis_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("sbu_mis_misalign", {63'd0, misalign}, 64'd1);
    tick;

    // Non-memory instruction passes straight through.
    issue(1'b0, 1'b0, F3_LW, 64'h0000_0000_0000_0003, 64'd9);
    chk("nomem_out_valid", {63'd0, out_valid}, 64'd1);
    chk("nomem_misalign", {63'd0, misalign}, 64'd0);
    chk("nomem_ld_data", ld_data, 64'd0);
    chk("nomem_req_valid", {63'd0, bus_req_valid}, 64'd0);
    tick;

    // mem_r and mem_w together: store wins; SB at top lane.
    issue(1'b1, 1'b1, F3_SB, 64'h0000_0000_0000_2007, 64'h0000_0000_0000_00AB);
    chk("sb_req_we", {63'd0, bus_req_we}, 64'd1);
    chk("sb_wstrb", {56'd0, bus_req_wstrb}, 64'h0000_0000_0000_0080);
    chk("sb_wdata", bus_req_wdata, 64'hAB00_0000_0000_0000);
    chk("sb_req_addr", bus_req_addr, 64'h0000_0000_0000_2000);
    tick;
    bus_rsp_valid = 1'b1;
    tick;
    bus_rsp_valid = 1'b0;
    chk("sb_out_valid", {63'd0, out_valid}, 64'd1);
    tick;

    // Backpressure on both the bus request and write-back.
    bus_req_ready = 1'b0;
    issue(1'b1, 1'b0, F3_LW, 64'h0000_0000_0000_3004, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_valid", {63'd0, bus_req_valid}, 64'd1);
      chk("bp_req_addr", bus_req_addr, 64'h0000_0000_0000_3000);
      chk("bp_req_we", {63'd0, bus_req_we}, 64'd0);
      chk("bp_req_in_ready", {63'd0, in_ready}, 64'd0);
      tick;
    end
    bus_req_ready = 1'b1;
    chk("bp_req_valid_last", {63'd0, bus_req_valid}, 64'd1);
    tick;
    chk("bp_rsp_req_valid", {63'd0, bus_req_valid}, 64'd0);
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'h8765_4321_0000_0000;
    out_ready = 1'b0;
    tick;
    // A stray response while in DONE must not disturb the result.
    bus_rsp_data = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 2; i++) begin
      chk("bp_done_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_done_ld_data", ld_data, 64'hFFFF_FFFF_8765_4321);
      chk("bp_done_in_ready", {63'd0, in_ready}, 64'd0);
      tick;
    end
    bus_rsp_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_handshake_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_handshake_ld_data", ld_data, 64'hFFFF_FFFF_8765_4321);
    tick;
    chk("bp_after_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_after_out_valid", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
